pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and reports its period and high time (duty) in units of a sampling tick. It is the receive end of the PWM path: it decodes what the PWM generator produces, e.g. a generator loopback on the board or an external PWM source on a GPIO. Results feed LED/7-segment display logic or a self-check comparator.

## Interface

- `WIDTH`, default 9: bit width of the period/duty counters and outputs; matches the generator's period width.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: one-`clk` sample strobe, e.g. the 1 ms clock-divider pulse; all measurement advances only on `tick`.
- `pwm_in` input 1: PWM signal; may be asynchronous to `clk`.
- `period` output WIDTH: last measured period in ticks, rising edge to rising edge.
- `duty` output WIDTH: last measured high time in ticks.
- `valid` output 1: one-`clk` pulse when `period`/`duty` update.
- `timeout` output 1: no rising edge seen within 2^WIDTH−1 ticks; sticky until the next valid measurement.
- `stuck_level` output 1: sampled level of `pwm_in` at the moment `timeout` was set.

## Operation

- **Synchronizer:** `pwm_in` passes through 2 `clk` flops every cycle giving `s2`. On a `tick` cycle, `lvl = s2`, `prev` holds `lvl` from the previous tick, and `rise = lvl & ~prev`.
- **Counters:**
  - `tot_cnt` (WIDTH) counts ticks since the last rising edge.
  - `high_cnt` (WIDTH) counts ticks sampled high since the last rising edge.
  - Both are unsigned. They never wrap; the timeout check fires before that.
- **States:**
  - WAIT_EDGE (reset state): counters are ignored. On `tick & rise`: `tot_cnt`=1, `high_cnt`=1, go to MEASURE. This first edge produces no output, because the preceding cycle is partial.
  - MEASURE, on `tick & rise`: latch `period`=`tot_cnt`, `duty`=`high_cnt`, pulse `valid`, clear `timeout`. Then `tot_cnt`=1, `high_cnt`=1 and stay in MEASURE.
  - MEASURE, on `tick & ~rise` with `tot_cnt` < 2^WIDTH−1: `tot_cnt`+=1, and `high_cnt`+=1 if `lvl`=1.
  - MEASURE, on `tick & ~rise` with `tot_cnt` = 2^WIDTH−1: set `timeout`=1, `stuck_level`=`lvl`, go to WAIT_EDGE. `period`/`duty` are unchanged and `valid` does not pulse.
- **No tick:** with `tick`=0, nothing except the synchronizer changes.
- **Invariant:** `duty` ≤ `period` always. A constant-high or constant-low input never yields `valid`.
- **Reset values:**
  - `period`=0, `duty`=0, `valid`=0, `timeout`=0, `stuck_level`=0.
  - State WAIT_EDGE, `prev`=1, so a line already high at reset is not treated as an edge.
  - Synchronizer flops 0.
- **Reset mid-measurement:** the in-progress count is discarded and the next rising edge restarts from WAIT_EDGE.

## Timing

- All outputs are registered.
- `valid` is high for exactly the one `clk` cycle after the `tick` cycle that samples `rise`.
- Latency: a `pwm_in` rising edge reaches `s2` after 2 `clk` edges. It is then sampled on the next `tick`, and `valid` follows 1 `clk` later.
- Pulse width resolution is ±1 tick. Any high or low phase shorter than 1 tick may be missed.
- `tick` held at 1 every cycle is legal; the block then measures in `clk` units.
- `reset` takes priority over `tick` in the same cycle.

## Structure

- Shared package `pwm_pkg` holds:
  - the state enum (WAIT_EDGE, MEASURE);
  - `PWM_WIDTH` = 9, shared with the generator;
  - the `PWM_MAX` constant = 2^WIDTH−1.
- Sub-module `pwm_edge_sync` contains the 2-flop synchronizer, the tick-gated `lvl`/`prev` registers and `rise`. The FSM and counters stay in `pwm_capture`.

## Test plan

- **Basic measurement:** `tick` every cycle; `pwm_in` repeats 3 high / 5 low → first `valid` follows the second rising edge with `period`=8 and `duty`=3, then every 8 cycles.
- **Tick gating:** `tick` every 4th `clk`; `pwm_in` is 12 `clk` high / 28 `clk` low → `period`=10, `duty`=3, `valid` exactly 1 `clk` wide.
- **Stuck low:** after a valid measurement, hold `pwm_in`=0 → `timeout`=1 and `stuck_level`=0 after 511 ticks with `WIDTH`=9. `period`/`duty` hold their old values. The next full cycle clears `timeout` and pulses `valid`.
- **Stuck high and reset level:** `pwm_in`=1 before and through reset → no `valid` ever. `timeout` only after a rising edge has been seen, then 511 ticks high with `stuck_level`=1.
- **Duty extremes:** 1 high / 9 low → `period`=10, `duty`=1. 9 high / 1 low → `period`=10, `duty`=9.
- **Reset mid-measurement:** assert `reset` for 1 cycle in the middle of a high phase → outputs return to 0. The first edge after reset gives no `valid`; the second edge gives a correct measurement.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture path.
package pwm_pkg;

    // Counter width shared with the PWM generator's period register.
    localparam int PWM_WIDTH = 9;

    // Largest count a PWM_WIDTH counter may reach before timeout fires.
    localparam logic [PWM_WIDTH-1:0] PWM_MAX = {PWM_WIDTH{1'b1}};

    // Capture FSM: idle until the first edge, then measure edge to edge.
    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings pwm_in into the clk domain and detects rising edges on tick samples.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pwm_in,
    output logic lvl,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Two-flop synchronizer, runs every clk regardless of tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

    // Level seen at the previous tick; reset high so a line that is already
    // high when reset drops is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
        end else if (tick) begin
            prev <= s2;
        end
    end

    // The level sampled on a tick is s2 itself, so the FSM acts in the same
    // cycle the tick arrives and valid lands one clk later.
    assign lvl  = s2;
    assign rise = s2 & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in tick units, flags a dead input.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic lvl;
    logic rise;

    pwm_state_t       state,    state_nxt;
    logic [WIDTH-1:0] tot_cnt,  tot_nxt;
    logic [WIDTH-1:0] high_cnt, high_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             stuck_nxt;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise)
    );

    // State, counters and all outputs are registered; reset wins over tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_EDGE;
            tot_cnt     <= CNT_ZERO;
            high_cnt    <= CNT_ZERO;
            period      <= CNT_ZERO;
            duty        <= CNT_ZERO;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state       <= state_nxt;
            tot_cnt     <= tot_nxt;
            high_cnt    <= high_nxt;
            period      <= period_nxt;
            duty        <= duty_nxt;
            valid       <= valid_nxt;
            timeout     <= timeout_nxt;
            stuck_level <= stuck_nxt;
        end
    end

    // Next-state and counter update; nothing moves on non-tick cycles.
    always_comb begin
        state_nxt   = state;
        tot_nxt     = tot_cnt;
        high_nxt    = high_cnt;
        period_nxt  = period;
        duty_nxt    = duty;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;
        stuck_nxt   = stuck_level;

        if (tick) begin
            case (state)
                WAIT_EDGE: begin
                    // First edge only starts a cycle; what came before is partial.
                    if (rise) begin
                        tot_nxt   = CNT_ONE;
                        high_nxt  = CNT_ONE;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt  = tot_cnt;
                        duty_nxt    = high_cnt;
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b0;
                        tot_nxt     = CNT_ONE;
                        high_nxt    = CNT_ONE;
                    end else if (tot_cnt != CNT_MAX) begin
                        tot_nxt = tot_cnt + CNT_ONE;
                        if (lvl) begin
                            high_nxt = high_cnt + CNT_ONE;
                        end
                    end else begin
                        // Counter would wrap: give up and report the stuck level.
                        timeout_nxt = 1'b1;
                        stuck_nxt   = lvl;
                        state_nxt   = WAIT_EDGE;
                    end
                end
                default: state_nxt = WAIT_EDGE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed checks of pwm_capture with WIDTH = 9.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       pwm_in = 1'b0;
    logic [8:0] period;
    logic [8:0] duty;
    logic       valid;
    logic       timeout;
    logic       stuck_level;

    int checks = 0;
    int errors = 0;

    int tdiv   = 1;
    int tick_en = 1;
    int cyc    = 0;

    // Monitor bookkeeping, written only by the monitor process.
    int   vcnt = 0;
    int   wide = 0;
    int   mcyc = 0;
    int   last_vcyc = 0;
    int   vgap = 0;
    int   last_p = 0;
    int   last_d = 0;
    logic prev_v = 1'b0;

    pwm_capture #(.WIDTH(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .pwm_in      (pwm_in),
        .period      (period),
        .duty        (duty),
        .valid       (valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mcyc++;
        if (valid) begin
            vcnt++;
            vgap = mcyc - last_vcyc;
            last_vcyc = mcyc;
            last_p = int'(period);
            last_d = int'(duty);
            if (prev_v) wide++;
        end
        prev_v = valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One clk of stimulus: set pwm level and tick just after the edge.
    task automatic step(input logic l);
        @(posedge clk);
        #1;
        pwm_in = l;
        tick = (tick_en != 0) && (cyc % tdiv == 0);
        cyc++;
    endtask

    task automatic hold(input logic l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic run(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic do_reset(input logic l, input int n);
        reset = 1'b1;
        hold(l, n);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    int v0;
    int w0;

    initial begin
        // Reset state
        do_reset(1'b0, 3);
        @(negedge clk);
        chk("rst_period", int'(period), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_stuck", int'(stuck_level), 0);

        // Basic: tick every clk, 3 high / 5 low
        tdiv = 1;
        hold(1'b0, 4);
        v0 = vcnt;
        run(3, 5, 4);
        hold(1'b0, 6);
        chk("basic_vcnt", vcnt - v0, 3);
        chk("basic_period", last_p, 8);
        chk("basic_duty", last_d, 3);
        chk("basic_gap", vgap, 8);
        chk("basic_timeout", int'(timeout), 0);

        // Tick gating: tick every 4th clk, 12 high / 28 low
        do_reset(1'b0, 2);
        tdiv = 4;
        hold(1'b0, 8);
        v0 = vcnt;
        w0 = wide;
        run(12, 28, 3);
        hold(1'b0, 12);
        chk("gate_vcnt", vcnt - v0, 2);
        chk("gate_period", last_p, 10);
        chk("gate_duty", last_d, 3);
        chk("gate_gap", vgap, 40);
        chk("gate_width", wide - w0, 0);

        // Duty extremes
        do_reset(1'b0, 2);
        tdiv = 1;
        hold(1'b0, 4);
        v0 = vcnt;
        run(1, 9, 3);
        hold(1'b0, 6);
        chk("dmin_vcnt", vcnt - v0, 2);
        chk("dmin_period", last_p, 10);
        chk("dmin_duty", last_d, 1);
        do_reset(1'b0, 2);
        hold(1'b0, 4);
        v0 = vcnt;
        run(9, 1, 3);
        hold(1'b0, 6);
        chk("dmax_vcnt", vcnt - v0, 2);
        chk("dmax_period", last_p, 10);
        chk("dmax_duty", last_d, 9);

        // Stuck low after a good measurement
        do_reset(1'b0, 2);
        hold(1'b0, 4);
        run(3, 5, 2);
        hold(1'b0, 4);
        chk("slow_pre_period", int'(period), 8);
        v0 = vcnt;
        hold(1'b0, 480);
        chk("slow_early_to", int'(timeout), 0);
        hold(1'b0, 40);
        chk("slow_timeout", int'(timeout), 1);
        chk("slow_stuck", int'(stuck_level), 0);
        chk("slow_period", int'(period), 8);
        chk("slow_duty", int'(duty), 3);
        chk("slow_novalid", vcnt - v0, 0);
        run(2, 4, 2);
        hold(1'b0, 5);
        chk("slow_rec_vcnt", vcnt - v0, 1);
        chk("slow_rec_to", int'(timeout), 0);
        chk("slow_rec_period", int'(period), 6);
        chk("slow_rec_duty", int'(duty), 2);

        // Stuck high through reset: no edge, no valid, no timeout
        tick_en = 0;
        hold(1'b1, 2);
        do_reset(1'b1, 3);
        hold(1'b1, 4);
        tick_en = 1;
        v0 = vcnt;
        hold(1'b1, 600);
        chk("shigh_novalid", vcnt - v0, 0);
        chk("shigh_no_to", int'(timeout), 0);
        hold(1'b0, 4);
        hold(1'b1, 500);
        chk("shigh_early_to", int'(timeout), 0);
        hold(1'b1, 20);
        chk("shigh_timeout", int'(timeout), 1);
        chk("shigh_stuck", int'(stuck_level), 1);
        chk("shigh_novalid2", vcnt - v0, 0);

        // Reset in the middle of a high phase
        do_reset(1'b0, 2);
        hold(1'b0, 4);
        run(3, 5, 2);
        hold(1'b0, 4);
        chk("mid_pre_period", int'(period), 8);
        hold(1'b1, 2);
        tick_en = 0;
        do_reset(1'b1, 1);
        @(negedge clk);
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_duty", int'(duty), 0);
        chk("mid_rst_to", int'(timeout), 0);
        hold(1'b1, 3);
        tick_en = 1;
        v0 = vcnt;
        hold(1'b0, 5);
        run(1, 9, 1);
        chk("mid_first_edge", vcnt - v0, 0);
        run(1, 9, 2);
        hold(1'b0, 5);
        chk("mid_vcnt", vcnt - v0, 2);
        chk("mid_period", last_p, 10);
        chk("mid_duty", last_d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
